// File: rtl/ed25519.sv
// Ed25519 scalar multiplication R = n*P in extended twisted Edwards coordinates.
// One shared interleaved modular multiplier, LSB-first double-and-add.
module ed25519 #(
  parameter int SCALAR_BITS = 256,
  parameter logic [255:0] D2 =
    256'h2406d9dc56dffce7198e80f2eef3d13000e0149a8283b156ebd69b9426b2f159
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] n,
  input  logic [255:0] x,
  input  logic [255:0] y,
  input  logic [255:0] z,
  input  logic [255:0] t,
  output logic         done,
  output logic [255:0] x3,
  output logic [255:0] y3,
  output logic [255:0] z3,
  output logic [255:0] t3
);

  localparam logic [255:0] QM = {1'b0, {250{1'b1}}, 5'b01101};
  localparam int CW = $clog2(SCALAR_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BIT, S_LOAD, S_MUL, S_STORE, S_DONE
  } state_t;

  function automatic logic [255:0] addm(
    input logic [255:0] a,
    input logic [255:0] b
  );
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, QM}) s = s - {1'b0, QM};
    return s[255:0];
  endfunction

  function automatic logic [255:0] subm(
    input logic [255:0] a,
    input logic [255:0] b
  );
    logic [255:0] d;
    d = a - b;
    if (a < b) d = d + QM;
    return d;
  endfunction

  state_t state, state_n;

  logic [255:0]  nsh;
  logic [CW-1:0] cnt;
  logic          dbl;
  logic [3:0]    step;
  logic [5:0]    mcnt;
  logic [255:0]  acc, acc_n, ma, mb;
  logic [255:0]  rx, ry, rz, rt;
  logic [255:0]  qx, qy, qz, qt;
  logic [255:0]  ta, tb, tc, td;
  logic [255:0]  px, py, pz, pt;
  logic [255:0]  e, f, g, h;
  logic [255:0]  opa, opb;
  logic          bits_done, mlast, last_step;

  assign bits_done = (cnt == CW'(SCALAR_BITS));
  assign mlast     = (mcnt == 6'd63);
  assign last_step = (step == 4'd8);

  // first operand is R for an add, Q for a doubling
  always_comb begin
    px = dbl ? qx : rx;
    py = dbl ? qy : ry;
    pz = dbl ? qz : rz;
    pt = dbl ? qt : rt;
    e = subm(tb, ta);
    f = subm(td, tc);
    g = addm(td, tc);
    h = addm(tb, ta);
    opa = '0;
    opb = '0;
    case (step)
      4'd0: begin opa = subm(py, px); opb = subm(qy, qx); end
      4'd1: begin opa = addm(py, px); opb = addm(qy, qx); end
      4'd2: begin opa = pt; opb = D2; end
      4'd3: begin opa = tc; opb = qt; end
      4'd4: begin opa = pz; opb = qz; end
      4'd5: begin opa = e;  opb = f;  end
      4'd6: begin opa = g;  opb = h;  end
      4'd7: begin opa = e;  opb = h;  end
      4'd8: begin opa = f;  opb = g;  end
      default: ;
    endcase
  end

  // four MSB-first shift-add steps per cycle
  always_comb begin
    acc_n = acc;
    for (int i = 0; i < 4; i++) begin
      acc_n = addm(acc_n, acc_n);
      if (mb[255-i]) acc_n = addm(acc_n, ma);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = S_BIT;
      S_BIT:   state_n = bits_done ? S_DONE : S_LOAD;
      S_LOAD:  state_n = S_MUL;
      S_MUL:   if (mlast) state_n = S_STORE;
      S_STORE: state_n = (last_step && dbl) ? S_BIT : S_LOAD;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nsh <= '0; cnt <= '0; dbl <= 1'b0; step <= '0;
      mcnt <= '0; acc <= '0; ma <= '0; mb <= '0;
      rx <= '0; ry <= '0; rz <= '0; rt <= '0;
      qx <= '0; qy <= '0; qz <= '0; qt <= '0;
      ta <= '0; tb <= '0; tc <= '0; td <= '0;
      x3 <= '0; y3 <= '0; z3 <= '0; t3 <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          nsh <= n; cnt <= '0;
          rx <= '0; ry <= 256'd1; rz <= 256'd1; rt <= '0;
          qx <= x; qy <= y; qz <= z; qt <= t;
        end
        S_BIT: begin
          if (bits_done) begin
            x3 <= rx; y3 <= ry; z3 <= rz; t3 <= rt;
          end else begin
            dbl <= ~nsh[0];
            step <= '0;
          end
        end
        S_LOAD: begin
          ma <= opa; mb <= opb;
          acc <= '0; mcnt <= '0;
        end
        S_MUL: begin
          acc <= acc_n;
          mb <= mb << 4;
          mcnt <= mcnt + 6'd1;
        end
        S_STORE: begin
          case (step)
            4'd0: ta <= acc;
            4'd1: tb <= acc;
            4'd2: tc <= acc;
            4'd3: tc <= acc;
            4'd4: td <= addm(acc, acc);
            4'd5: if (dbl) qx <= acc; else rx <= acc;
            4'd6: if (dbl) qy <= acc; else ry <= acc;
            4'd7: if (dbl) qt <= acc; else rt <= acc;
            4'd8: if (dbl) qz <= acc; else rz <= acc;
            default: ;
          endcase
          if (last_step) begin
            step <= '0;
            if (dbl) begin
              nsh <= nsh >> 1;
              cnt <= cnt + CW'(1);
            end else begin
              dbl <= 1'b1;
            end
          end else begin
            step <= step + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ed25519.sv
// Directed bench for ed25519 with a GF(2^255-19) reference model.
// Short scalar width keeps each run to a few thousand cycles.
module tb_ed25519;

  localparam int SB = 4;
  localparam logic [255:0] QM = {1'b0, {250{1'b1}}, 5'b01101};

  typedef struct packed {
    logic [255:0] x, y, z, t;
  } pt_t;

  typedef struct {
    string        nm;
    logic [255:0] n;
    pt_t          p;
    pt_t          e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [255:0] n = '0, x = '0, y = '0, z = '0, t = '0;
  logic done;
  logic [255:0] x3, y3, z3, t3;

  always #5 clk = ~clk;

  ed25519 #(.SCALAR_BITS(SB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n),
    .x(x), .y(y), .z(z), .t(t), .done(done),
    .x3(x3), .y3(y3), .z3(z3), .t3(t3)
  );

  int errs = 0;
  int checks = 0;
  logic [255:0] d2m;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] fmul(input logic [255:0] a,
                                        input logic [255:0] b);
    logic [511:0] p;
    p = {256'b0, a} * {256'b0, b};
    p = p % {256'b0, QM};
    return p[255:0];
  endfunction

  function automatic logic [255:0] fadd(input logic [255:0] a,
                                        input logic [255:0] b);
    logic [256:0] s;
    s = ({1'b0, a} + {1'b0, b}) % {1'b0, QM};
    return s[255:0];
  endfunction

  function automatic logic [255:0] fsub(input logic [255:0] a,
                                        input logic [255:0] b);
    logic [256:0] s;
    s = ({1'b0, a} + {1'b0, QM} - {1'b0, b}) % {1'b0, QM};
    return s[255:0];
  endfunction

  function automatic logic [255:0] fpow(input logic [255:0] a,
                                        input logic [255:0] ex);
    logic [255:0] r;
    r = 256'd1;
    for (int i = 255; i >= 0; i--) begin
      r = fmul(r, r);
      if (ex[i]) r = fmul(r, a);
    end
    return r;
  endfunction

  function automatic pt_t padd(input pt_t p1, input pt_t p2);
    logic [255:0] a, b, c, d, e, f, g, h;
    pt_t r;
    a = fmul(fsub(p1.y, p1.x), fsub(p2.y, p2.x));
    b = fmul(fadd(p1.y, p1.x), fadd(p2.y, p2.x));
    c = fmul(fmul(p1.t, d2m), p2.t);
    d = fmul(fadd(p1.z, p1.z), p2.z);
    e = fsub(b, a); f = fsub(d, c);
    g = fadd(d, c); h = fadd(b, a);
    r.x = fmul(e, f); r.y = fmul(g, h);
    r.t = fmul(e, h); r.z = fmul(f, g);
    return r;
  endfunction

  function automatic pt_t mk(input logic [255:0] a, input logic [255:0] b,
                             input logic [255:0] c, input logic [255:0] d);
    pt_t r;
    r.x = a; r.y = b; r.z = c; r.t = d;
    return r;
  endfunction

  function automatic pt_t smul(input logic [255:0] k, input pt_t p);
    pt_t r, q;
    r = mk(0, 1, 1, 0);
    q = p;
    for (int i = 0; i < SB; i++) begin
      if (k[i]) r = padd(r, q);
      q = padd(q, q);
    end
    return r;
  endfunction

  task automatic wait_done(input string nm, output int lat);
    lat = 1;
    while (!done && lat < 20000) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_done_seen"}, {255'b0, done}, 256'd1);
  endtask

  task automatic launch(input logic [255:0] k, input pt_t p);
    @(negedge clk);
    start = 1'b1; n = k;
    x = p.x; y = p.y; z = p.z; t = p.t;
    @(negedge clk);
    start = 1'b0;
    n = 256'hdead; x = 256'd11; y = 256'd22; z = 256'd33; t = 256'd44;
  endtask

  task automatic check_out(input string nm, input pt_t e);
    chk({nm, "_x3"}, x3, e.x);
    chk({nm, "_y3"}, y3, e.y);
    chk({nm, "_z3"}, z3, e.z);
    chk({nm, "_t3"}, t3, e.t);
    @(negedge clk);
    chk({nm, "_done_low"}, {255'b0, done}, 256'd0);
    @(negedge clk);
    chk({nm, "_hold"}, {x3, y3, z3, t3} == e ? 256'd1 : 256'd0, 256'd1);
  endtask

  vec_t v[5];
  int   lat[5];
  int   pulses;
  int   tmp;
  pt_t  p3579, pid, pneg;

  initial begin
    d2m = fmul(QM - 256'd121665, fpow(256'd121666, QM - 256'd2));
    d2m = fadd(d2m, d2m);
    p3579 = mk(3, 5, 7, 9);
    pid   = mk(0, 1, 1, 0);
    pneg  = mk(QM - 256'd1, 1, 1, 0);

    v[0] = '{"n0",   256'd0, p3579, mk(0, 1, 1, 0)};
    v[1] = '{"n1",   256'd1, p3579, mk(84, 140, 196, 60)};
    v[2] = '{"n3id", 256'd3, pid,   mk(0, 1024, 1024, 0)};
    v[3] = '{"nqm1", 256'd1, pneg,
             mk(QM - 256'd4, 4, 4, QM - 256'd4)};
    v[4] = '{"n2",   256'd2, p3579, smul(256'd2, p3579)};

    repeat (3) @(negedge clk);
    chk("rst_done", {255'b0, done}, 256'd0);
    chk("rst_out", {x3, y3, z3, t3} == '0 ? 256'd1 : 256'd0, 256'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      launch(v[i].n, v[i].p);
      wait_done(v[i].nm, lat[i]);
      check_out(v[i].nm, v[i].e);
    end
    chk("n2_lt_q",
        (x3 < QM && y3 < QM && z3 < QM && t3 < QM) ? 256'd1 : 256'd0,
        256'd1);
    chk("lat_same_pop", 256'(lat[4]), 256'(lat[1]));
    chk("lat_more_pop", lat[2] > lat[1] ? 256'd1 : 256'd0, 256'd1);
    chk("lat_less_pop", lat[0] < lat[1] ? 256'd1 : 256'd0, 256'd1);

    // start during RUN must be ignored
    launch(256'd1, p3579);
    repeat (100) @(negedge clk);
    start = 1'b1; n = 256'd3;
    x = 0; y = 1; z = 1; t = 0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_hold", {x3, y3, z3, t3} == v[4].e ? 256'd1 : 256'd0, 256'd1);
    wait_done("busy", tmp);
    check_out("busy", v[1].e);
    pulses = 0;
    repeat (200) @(negedge clk) if (done) pulses++;
    chk("busy_no_restart", 256'(pulses), 256'd0);

    // abort by reset mid-run
    launch(256'd3, p3579);
    repeat (700) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out", {x3, y3, z3, t3} == '0 ? 256'd1 : 256'd0, 256'd1);
    chk("abort_done", {255'b0, done}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (50) @(negedge clk) if (done) pulses++;
    chk("abort_no_done", 256'(pulses), 256'd0);
    launch(256'd1, pneg);
    wait_done("fresh", tmp);
    check_out("fresh", v[3].e);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ed25519.md
Name: ed25519

Overview:
- Sequential Ed25519 scalar-multiplication engine: computes R = n·P on the twisted Edwards curve −x²+y²=1+d·x²y² over GF(q), q = 2^255−19.
- Operates on points in extended projective coordinates (X:Y:Z:T); no inversion or normalisation is performed.
- Sits beside the signing/verification controller, which launches it with a one-cycle start and collects the result on done.

Parameters:
- SCALAR_BITS, 256, number of scalar bits processed (LSB first).
- D2, 2·d mod q (d = −121665/121666 mod q), 255-bit curve constant used in point addition.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle launch pulse; accepted only when idle.
- n  input  256  scalar.
- x, y, z, t  input  256 each  input point P; values must be < q (upper bit 0).
- done  output  1  one-cycle pulse: result valid.
- x3, y3, z3, t3  output  256 each  result point, unsigned, each in [0, q), upper bit 0.

Behaviour:
- Reset (async, rst_n=0): state IDLE; done=0; x3=y3=z3=t3=0; internal registers cleared. Reset mid-operation aborts the computation immediately, with no done pulse.
- IDLE: on posedge with start=1, latch n, x, y, z, t. Set R=(0,1,1,0) (neutral) and Q=P. Go to RUN. Inputs may change freely after the start cycle.
- start while busy is ignored.
- RUN: for i = 0 .. SCALAR_BITS−1:
  - if n[i]=1, R = R ⊕ Q;
  - always Q = Q ⊕ Q.
  - When n[i]=0 the add is skipped.
- Point add ⊕ (unified formula, also used for doubling, no special cases):
  - A=(Y1−X1)(Y2−X2), B=(Y1+X1)(Y2+X2), C=T1·D2·T2, D=2·Z1·Z2
  - E=B−A, F=D−C, G=D+C, H=B+A
  - X3=E·F, Y3=G·H, T3=E·H, Z3=F·G
- Arithmetic rules:
  - All adds/subs are mod q, with result in [0, q).
  - Subtraction adds q on borrow.
  - Multiplication uses a shared sequential modular multiplier (interleaved shift-add with conditional subtract, or equivalent), fully reduced.
  - Inputs are not on-curve checked; the formulas are applied as-is.
- Completion: after the last bit, load R into x3/y3/z3/t3, pulse done high for exactly one cycle, return to IDLE.
- Outputs hold their value until the next completed operation. They do not change at start or during RUN.
- Latency depends only on SCALAR_BITS and on the number of set bits in n. It is never data-dependent beyond that.
- A new start is accepted in the cycle after done.

Test Plan:
- n=0, P=(3,5,7,9) -> done pulses once; (x3,y3,z3,t3)=(0,1,1,0).
- n=1, P=(3,5,7,9) -> x3=84, y3=140, z3=196, t3=60. Outputs unchanged for ≥2 cycles after done; done back to 0 the next cycle.
- n=3, P=(0,1,1,0) -> x3=0, y3=1024, z3=1024, t3=0.
- Reduction and borrow: n=1, P=(q−1,1,1,0) -> x3=q−4, y3=4, z3=4, t3=q−4.
- Control: pulse start again during RUN with different inputs -> ignored, first result unaffected. Assert rst_n=0 mid-RUN -> outputs 0, no done, and a fresh start then completes correctly.
- n=2, P=(3,5,7,9): result matches a software model of the same LSB-first algorithm. All outputs are < q.
